// File: rtl/fp_mult_pkg.sv
// rtl/fp_mult_pkg.sv - shared constants and stage payload for the FP multiply post-stage
package fp_mult_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;
  localparam int E_W    = EXP_W + 2;  // signed working exponent, wide enough for 255+255

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  localparam int FLAG_ZERO      = 0;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_INVALID   = 3;

  typedef struct packed {
    logic                    sign;
    logic signed [E_W-1:0]   e;
    logic [FRAC_W-1:0]       frac;
    logic                    g;
    logic                    s;
    logic                    zero_op;
    logic                    inf_op;
  } s1_payload_t;

endpackage

// File: rtl/fp_round_rne.sv
// rtl/fp_round_rne.sv - fraction rounding helper; FP_MULT_ROUND_NEAREST_EN selects RNE, else truncation
module fp_round_rne
  import fp_mult_pkg::*;
(
  input  logic [FRAC_W-1:0] frac_i,
  input  logic              g_i,
  input  logic              s_i,
  output logic [FRAC_W-1:0] frac_o,
  output logic              carry_o
);

`ifdef FP_MULT_ROUND_NEAREST_EN
  logic round_up;

  // Ties go to the even fraction: a lone guard bit only rounds an odd LSB.
  assign round_up          = g_i & (s_i | frac_i[0]);
  assign {carry_o, frac_o} = {1'b0, frac_i} + {{FRAC_W{1'b0}}, round_up};
`else
  logic unused_round;

  assign unused_round = g_i ^ s_i;
  assign frac_o       = frac_i;
  assign carry_o      = 1'b0;
`endif

endmodule

// File: rtl/fp_mult_norm_round_stage.sv
// rtl/fp_mult_norm_round_stage.sv - 2-stage normalise/round/pack after the mantissa multiplier
// Rounding follows FP_MULT_ROUND_NEAREST_EN (round-to-nearest-even when defined, truncation otherwise).
module fp_mult_norm_round_stage #(
  parameter int PROD_W = 28,
  parameter int EXP_W  = 8,
  parameter int BIAS   = 127
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp_a,
  input  logic [EXP_W-1:0]  in_exp_b,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic [3:0]        out_flags
);
  import fp_mult_pkg::*;

  localparam int GI = PROD_W - 2 - FRAC_W;  // guard bit position in the normalised product
  localparam logic signed [E_W-1:0] E_INF  = E_W'((1 << EXP_W) - 1);
  localparam logic signed [E_W-1:0] E_ZERO = '0;

  logic [E_W-1:0]    exp_sum;
  logic [E_W-1:0]    e_n;
  logic [PROD_W-2:0] prod_n;
  s1_payload_t       s1_new, s1_d, s1_q;
  logic              s1_v_d, s1_v_q;
  logic              s2_v_d, s2_v_q;
  logic [31:0]       result_d, result_q, res_n;
  logic [3:0]        flags_d, flags_q, flg_n;
  logic              s2_adv;
  logic [FRAC_W-1:0] frac_r;
  logic              carry_r;
  logic signed [E_W-1:0] e_r;

  assign s2_adv   = !s2_v_q || out_ready;
  assign in_ready = !s1_v_q || s2_adv;

  // Stage 1: drop the leading one so the fraction always starts at the same bit.
  always_comb begin
    exp_sum = E_W'(in_exp_a) + E_W'(in_exp_b);
    if (in_prod[PROD_W-1]) begin
      prod_n = in_prod[PROD_W-2:0];
      e_n    = exp_sum - E_W'(BIAS - 1);
    end else begin
      prod_n = {in_prod[PROD_W-3:0], 1'b0};
      e_n    = exp_sum - E_W'(BIAS);
    end
    s1_new.sign    = in_sign;
    s1_new.e       = e_n;
    s1_new.frac    = prod_n[PROD_W-2 -: FRAC_W];
    s1_new.g       = prod_n[GI];
    s1_new.s       = |prod_n[GI-1:0];
    s1_new.zero_op = (in_exp_a == '0) || (in_exp_b == '0);
    s1_new.inf_op  = (&in_exp_a) || (&in_exp_b);
  end

  fp_round_rne u_round (
    .frac_i  (s1_q.frac),
    .g_i     (s1_q.g),
    .s_i     (s1_q.s),
    .frac_o  (frac_r),
    .carry_o (carry_r)
  );

  // Stage 2: special operands win over range checks, which win over the normal pack.
  always_comb begin
    e_r   = s1_q.e + E_W'(carry_r);
    res_n = {s1_q.sign, e_r[EXP_W-1:0], frac_r};
    flg_n = '0;
    if (s1_q.inf_op && s1_q.zero_op) begin
      res_n                = QNAN;
      flg_n[FLAG_INVALID]  = 1'b1;
    end else if (s1_q.inf_op) begin
      res_n                = {s1_q.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      flg_n[FLAG_OVERFLOW] = 1'b1;
    end else if (s1_q.zero_op) begin
      res_n                = {s1_q.sign, {(EXP_W + FRAC_W){1'b0}}};
      flg_n[FLAG_ZERO]     = 1'b1;
    end else if (e_r >= E_INF) begin
      res_n                = {s1_q.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      flg_n[FLAG_OVERFLOW] = 1'b1;
    end else if (e_r <= E_ZERO) begin
      res_n                 = {s1_q.sign, {(EXP_W + FRAC_W){1'b0}}};
      flg_n[FLAG_UNDERFLOW] = 1'b1;
      flg_n[FLAG_ZERO]      = 1'b1;
    end
  end

  always_comb begin
    s1_v_d   = s1_v_q;
    s1_d     = s1_q;
    s2_v_d   = s2_v_q;
    result_d = result_q;
    flags_d  = flags_q;
    if (in_ready) begin
      s1_v_d = in_valid;
      if (in_valid) s1_d = s1_new;
    end
    if (s2_adv) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        result_d = res_n;
        flags_d  = flg_n;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q   <= 1'b0;
      s2_v_q   <= 1'b0;
      s1_q     <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      s1_v_q   <= s1_v_d;
      s2_v_q   <= s2_v_d;
      s1_q     <= s1_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign out_valid  = s2_v_q;
  assign out_result = result_q;
  assign out_flags  = flags_q;

endmodule
